max_priority_arbiter: RTL and testbench

- Shares one downstream resource among four requesters (A..D). Each requester carries a 4-bit priority value.
- Grants the resource to the active requester with the numerically largest priority. Ties are broken round-robin.
- Holds the grant until the owner releases it or a hold timeout expires.
- Sits in front of the multi-input comparator datapath and sequences which input owns the shared resource, cycle by cycle.

---
 rtl/max_priority_arbiter_pkg.sv | 24 ++
 rtl/max_priority_arbiter_if.sv | 46 ++++
 rtl/max_priority_arbiter_rr_max_select.sv | 54 +++++
 rtl/max_priority_arbiter.sv | 143 ++++++++++++++
 tb/tb_max_priority_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/max_priority_arbiter_pkg.sv
// Shared types and constants for the max-priority round-robin arbiter.
// Holds the FSM encoding, requester indices and default sizing.
package max_priority_arbiter_pkg;

  localparam int PW_DEF      = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int TW_DEF      = 5;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/max_priority_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The arbiter uses the slave view; the requester side uses master.
interface max_priority_arbiter_if
  import max_priority_arbiter_pkg::*;
#(
  parameter int PW = PW_DEF
);

  logic [3:0]    req;
  logic [PW-1:0] pri_a;
  logic [PW-1:0] pri_b;
  logic [PW-1:0] pri_c;
  logic [PW-1:0] pri_d;
  logic          done;
  logic [3:0]    gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic          timeout;

  modport slave (
    input  req,
    input  pri_a,
    input  pri_b,
    input  pri_c,
    input  pri_d,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

  modport master (
    output req,
    output pri_a,
    output pri_b,
    output pri_c,
    output pri_d,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/max_priority_arbiter_rr_max_select.sv
// Combinational winner select: highest priority among active requesters,
// ties resolved by scanning upward from the slot after i_rr_ptr.
module rr_max_select
  import max_priority_arbiter_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic [3:0]    i_req,
  input  logic [PW-1:0] i_pri_a,
  input  logic [PW-1:0] i_pri_b,
  input  logic [PW-1:0] i_pri_c,
  input  logic [PW-1:0] i_pri_d,
  input  logic [1:0]    i_rr_ptr,
  output logic [1:0]    o_winner,
  output logic          o_valid
);

  logic [PW-1:0] w_pri [4];
  logic [PW-1:0] w_max;
  logic [1:0]    w_idx;
  logic          w_found;

  always_comb begin
    w_pri[IDX_A] = i_pri_a;
    w_pri[IDX_B] = i_pri_b;
    w_pri[IDX_C] = i_pri_c;
    w_pri[IDX_D] = i_pri_d;
  end

  // Inactive requesters never contribute to the maximum.
  always_comb begin
    w_max = '0;
    for (int i = 0; i < 4; i++) begin
      if (i_req[i] && (w_pri[i] > w_max)) begin
        w_max = w_pri[i];
      end
    end
  end

  always_comb begin
    o_valid  = |i_req;
    o_winner = i_rr_ptr;
    w_found  = 1'b0;
    w_idx    = i_rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_idx = i_rr_ptr + 2'(k);
      if (!w_found && i_req[w_idx] && (w_pri[w_idx] == w_max)) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/max_priority_arbiter.sv
// Four-way arbiter granting the highest-priority requester with round-robin
// tie break, grant hold until done / request drop / hold timeout.
module max_priority_arbiter
  import max_priority_arbiter_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input logic                    clk,
  input logic                    rst,
  max_priority_arbiter_if.slave  bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_gnt;
  logic [3:0]    w_gnt_nxt;
  logic [1:0]    r_gnt_id;
  logic [1:0]    w_gnt_id_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          r_timeout;
  logic          w_timeout_nxt;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;
  logic [1:0]    r_rr_ptr;
  logic [1:0]    w_rr_ptr_nxt;

  logic [1:0]    w_winner;
  logic          w_valid;
  logic          w_owner_req;
  logic          w_hit;
  logic          w_release;

  rr_max_select #(
    .PW (PW)
  ) u_sel (
    .i_req    (bus.req),
    .i_pri_a  (bus.pri_a),
    .i_pri_b  (bus.pri_b),
    .i_pri_c  (bus.pri_c),
    .i_pri_d  (bus.pri_d),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_owner_req = bus.req[r_gnt_id];
  assign w_hit       = (r_cnt == TW'(TIMEOUT));
  assign w_release   = bus.done | ~w_owner_req | w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_rr_ptr_nxt  = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_nxt    = onehot4(w_winner);
          w_gnt_id_nxt = w_winner;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = TW'(1);
        end else begin
          w_gnt_nxt    = '0;
          w_gnt_id_nxt = IDX_A;
          w_busy_nxt   = 1'b0;
          w_cnt_nxt    = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          // A forced release is flagged only when nothing else ended the hold.
          w_state_nxt   = ST_RELEASE;
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = IDX_A;
          w_busy_nxt    = 1'b0;
          w_cnt_nxt     = '0;
          w_rr_ptr_nxt  = r_gnt_id;
          w_timeout_nxt = w_hit & ~bus.done & w_owner_req;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = IDX_A;
        w_busy_nxt   = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_gnt_id  <= IDX_A;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_rr_ptr  <= IDX_D;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.gnt));
  a_gnt_id_match: assert property (@(posedge clk) disable iff (rst)
    (bus.gnt == 4'b0000) || (bus.gnt == onehot4(bus.gnt_id)));
  a_busy_match: assert property (@(posedge clk) disable iff (rst)
    bus.busy == (bus.gnt != 4'b0000));

endmodule

// File: tb/tb_max_priority_arbiter.sv
// Randomized and directed bench for max_priority_arbiter against an
// owner/gap/last-released reference model evaluated every clock.
module tb_max_priority_arbiter;

  localparam int TO = 16;

  logic clk;
  logic rst;

  max_priority_arbiter_if #(.PW(4)) bus ();

  max_priority_arbiter #(.PW(4), .TIMEOUT(TO), .TW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, how long, dead cycles left,
  // and who was released last (lowest rank among ties).
  int m_owner = -1;
  int m_hold  = 0;
  int m_gap   = 0;
  int m_last  = 3;
  bit m_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] rq, input int p0, input int p1,
                                  input int p2, input int p3, input int last);
    int p [4];
    int mx, best, bd, d;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    mx = -1; best = -1; bd = 99;
    for (int i = 0; i < 4; i++) if (rq[i] && p[i] > mx) mx = p[i];
    for (int i = 0; i < 4; i++) begin
      d = (i - last + 7) % 4;
      if (rq[i] && p[i] == mx && d < bd) begin
        bd = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_hold = 0; m_gap = 0; m_last = 3; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      if (bus.done || !bus.req[m_owner] || m_hold == TO) begin
        m_to    = (m_hold == TO) && !bus.done && bus.req[m_owner];
        m_last  = m_owner;
        m_owner = -1;
        m_hold  = 0;
        m_gap   = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (bus.req != 4'b0000) begin
        m_owner = ref_pick(bus.req, int'(bus.pri_a), int'(bus.pri_b),
                           int'(bus.pri_c), int'(bus.pri_d), m_last);
        m_hold  = 1;
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt",     32'(bus.gnt),     32'(eg));
    check("gnt_id",  32'(bus.gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("busy",    32'(bus.busy),    32'(m_owner >= 0));
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_pri(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    bus.pri_a = a; bus.pri_b = b; bus.pri_c = c; bus.pri_d = d;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req = 4'b0000; bus.done = 1'b0;
    set_pri(4'd0, 4'd0, 4'd0, 4'd0);
    cycle();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Priority win, then release via done and rr_ptr check.
    bus.req = 4'b1111; set_pri(4'd3, 4'd9, 4'd9, 4'd2);
    cycle();
    check("prio_gnt", 32'(bus.gnt), 32'h2);
    check("prio_id", 32'(bus.gnt_id), 32'd1);
    cycle();
    bus.done = 1'b1;
    cycle();
    check("prio_rel", 32'(bus.gnt), 32'h0);
    bus.done = 1'b0; set_pri(4'd5, 4'd5, 4'd5, 4'd5);
    cycle();
    cycle();
    check("prio_next_c", 32'(bus.gnt), 32'h4);

    // Round-robin across equal priorities.
    do_reset();
    bus.req = 4'b1111; set_pri(4'd5, 4'd5, 4'd5, 4'd5);
    cycle();
    for (int k = 0; k < 5; k++) begin
      check("rr_id", 32'(bus.gnt_id), 32'(k % 4));
      bus.done = 1'b1;
      cycle();
      bus.done = 1'b0;
      check("rr_gap1", 32'(bus.gnt), 32'h0);
      cycle();
      check("rr_gap2", 32'(bus.gnt), 32'h0);
      cycle();
    end

    // Inactive requesters excluded.
    do_reset();
    bus.req = 4'b0101; set_pri(4'd1, 4'd15, 4'd7, 4'd15);
    cycle();
    check("inact_gnt", 32'(bus.gnt), 32'h4);

    // Hold timeout and re-grant.
    do_reset();
    bus.req = 4'b0001;
    cycle();
    n = 0;
    while (bus.gnt[0] && n < 40) begin
      n++;
      cycle();
    end
    check("to_len", 32'(n), 32'(TO));
    check("to_pulse", 32'(bus.timeout), 32'd1);
    cycle();
    check("to_pulse_end", 32'(bus.timeout), 32'd0);
    cycle();
    check("to_regrant", 32'(bus.gnt), 32'h1);

    // Implicit release at hold count 5.
    do_reset();
    bus.req = 4'b0001;
    cycle();
    repeat (4) cycle();
    bus.req = 4'b0000;
    cycle();
    check("impl_gnt", 32'(bus.gnt), 32'h0);
    check("impl_to", 32'(bus.timeout), 32'd0);

    // done coinciding with the timeout count.
    do_reset();
    bus.req = 4'b0001;
    cycle();
    repeat (TO - 1) cycle();
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    check("coin_gnt", 32'(bus.gnt), 32'h0);
    check("coin_to", 32'(bus.timeout), 32'd0);

    // Reset while D owns the resource.
    do_reset();
    bus.req = 4'b1000;
    cycle();
    check("mid_gnt_d", 32'(bus.gnt), 32'h8);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b1111; set_pri(4'd7, 4'd7, 4'd7, 4'd7);
    cycle();
    check("mid_tie_a", 32'(bus.gnt), 32'h1);

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.done = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 0)
        set_pri(4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)));
      else
        set_pri(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
